// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: state encoding,
// stall/flush vector bit indices and the priority decoder result.
package pipe_ctrl_pkg;

  localparam int STALL_W = 5;
  localparam int REQ_W   = 4;

  // Stall/flush vector indices
  localparam int PCREG = 0;
  localparam int IFID  = 1;
  localparam int IDEX  = 2;
  localparam int EXMEM = 3;
  localparam int MEMWB = 4;

  // Request indices
  localparam int REQ_IF  = 0;
  localparam int REQ_ID  = 1;
  localparam int REQ_EX  = 2;
  localparam int REQ_MEM = 3;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_ALL = 5'b11111;
  localparam stall_bus_t FLUSH_ALL = 5'b11110;

  // The accept (freeze) cycle is merged into PC_RUN
  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_DRAIN = 2'd1,
    PC_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    stall_bus_t stall;
    stall_bus_t flush;
  } hold_t;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// Priority decoder: the highest requesting stage k holds stages 0..k and
// injects a bubble into register k+1.
module pipe_ctrl_prio
  import pipe_ctrl_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output hold_t            hold
);

  logic found;

  always_comb begin
    hold  = '0;
    found = 1'b0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (req[i] && !found) begin
        found           = 1'b1;
        hold.flush[i+1] = 1'b1;
      end
      if (found) hold.stall[i] = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-register stall/flush decode, exception entry
// (freeze, drain bus, flush, redirect) and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              cnt_clr,
  output logic [STALL_W-1:0] stall,
  output logic [STALL_W-1:0] flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              exc_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_e state_q, state_d;
  hold_t  prio;
  logic   accept;
  logic   bus_busy;

  pipe_ctrl_prio u_prio (
    .req  (req),
    .hold (prio)
  );

  assign bus_busy = req[REQ_IF] | req[REQ_MEM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PC_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall    = '0;
    flush    = '0;
    redirect = 1'b0;
    exc_busy = 1'b0;
    accept   = 1'b0;
    case (state_q)
      PC_RUN: begin
        if (exc_req) begin
          // Freeze everything in the accept cycle so nothing advances
          stall    = STALL_ALL;
          exc_busy = 1'b1;
          accept   = 1'b1;
          state_d  = bus_busy ? PC_DRAIN : PC_FLUSH;
        end else begin
          stall = prio.stall;
          flush = prio.flush;
        end
      end
      PC_DRAIN: begin
        stall    = STALL_ALL;
        exc_busy = 1'b1;
        if (!bus_busy) state_d = PC_FLUSH;
      end
      PC_FLUSH: begin
        flush    = FLUSH_ALL;
        redirect = 1'b1;
        exc_busy = 1'b1;
        state_d  = PC_RUN;
      end
      default: state_d = PC_RUN;
    endcase
    // Outputs are quiet for the whole reset pulse, not just after an edge
    if (rst) begin
      stall    = '0;
      flush    = '0;
      redirect = 1'b0;
      exc_busy = 1'b0;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         redirect_pc <= '0;
    else if (accept) redirect_pc <= exc_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (cnt_clr)
      stall_cycles <= '0;
    else if (stall[PCREG] && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        exc_req;
  logic [31:0] exc_target;
  logic        cnt_clr;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc_busy;
  logic [3:0]  stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .exc_req      (exc_req),
    .exc_target   (exc_target),
    .cnt_clr      (cnt_clr),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .exc_busy     (exc_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1000; exc_req = 1'b0; exc_target = '0; cnt_clr = 1'b0;
    #2;
    n_tests++;
    if (stall !== 5'b0 || flush !== 5'b0) begin
      n_fail++; $display("FAIL reset_vec: stall=%b flush=%b want 00000/00000", stall, flush);
    end
    n_tests++;
    if (redirect !== 1'b0 || exc_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: redirect=%b exc_busy=%b want 0/0", redirect, exc_busy);
    end
    tick();
    n_tests++;
    if (redirect_pc !== 32'h0 || stall_cycles !== 4'h0) begin
      n_fail++; $display("FAIL reset_regs: redirect_pc=%h cnt=%h want 0/0", redirect_pc, stall_cycles);
    end
    rst = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_single_stall();
    logic [3:0] rv [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0000};
    logic [4:0] sv [4] = '{5'b00111, 5'b01111, 5'b00001, 5'b00000};
    logic [4:0] fv [4] = '{5'b01000, 5'b10000, 5'b00010, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      req = rv[i];
      #1;
      n_tests++;
      if (stall !== sv[i] || flush !== fv[i]) begin
        n_fail++;
        $display("FAIL single_stall req=%b: stall=%b flush=%b want %b/%b", rv[i], stall, flush, sv[i], fv[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] rv [3] = '{4'b0011, 4'b1111, 4'b0110};
    logic [4:0] sv [3] = '{5'b00011, 5'b01111, 5'b00111};
    logic [4:0] fv [3] = '{5'b00100, 5'b10000, 5'b01000};
    for (int i = 0; i < 3; i++) begin
      req = rv[i];
      #1;
      n_tests++;
      if (stall !== sv[i] || flush !== fv[i] || exc_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL priority req=%b: stall=%b flush=%b busy=%b want %b/%b/0", rv[i], stall, flush, exc_busy, sv[i], fv[i]);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_exc_idle();
    exc_req = 1'b1; exc_target = 32'hBFC00380; req = 4'b0000;
    #1;
    n_tests++;
    if (stall !== 5'h1F || flush !== 5'h00 || exc_busy !== 1'b1 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_idle_accept: stall=%h flush=%h busy=%b redir=%b want 1f/00/1/0", stall, flush, exc_busy, redirect);
    end
    tick();
    exc_req = 1'b0; exc_target = 32'h0;
    #1;
    n_tests++;
    if (stall !== 5'h00 || flush !== 5'h1E || redirect !== 1'b1 || redirect_pc !== 32'hBFC00380 || exc_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_idle_flush: stall=%h flush=%h redir=%b pc=%h busy=%b want 00/1e/1/bfc00380/1",
               stall, flush, redirect, redirect_pc, exc_busy);
    end
    tick();
    n_tests++;
    if (exc_busy !== 1'b0 || redirect !== 1'b0 || stall !== 5'h00 || flush !== 5'h00) begin
      n_fail++;
      $display("FAIL exc_idle_after: busy=%b redir=%b stall=%h flush=%h want 0/0/00/00", exc_busy, redirect, stall, flush);
    end
  endtask

  task automatic test_exc_drain();
    // Cycles 1..3 hold req[3]; cycle 4 bus idle but still in DRAIN; cycle 5 FLUSH
    logic [3:0] rv [4] = '{4'b1000, 4'b1000, 4'b1010, 4'b0000};
    exc_target = 32'hBFC00380;
    for (int c = 0; c < 4; c++) begin
      req = rv[c];
      exc_req = 1'b1;
      if (c > 0) exc_target = 32'h80000180;
      #1;
      n_tests++;
      if (stall !== 5'h1F || flush !== 5'h00 || exc_busy !== 1'b1 || redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL exc_drain_cyc%0d: stall=%h flush=%h busy=%b redir=%b want 1f/00/1/0", c, stall, flush, exc_busy, redirect);
      end
      tick();
    end
    exc_req = 1'b0; req = 4'b0000;
    #1;
    n_tests++;
    if (flush !== 5'h1E || stall !== 5'h00 || redirect !== 1'b1 || redirect_pc !== 32'hBFC00380) begin
      n_fail++;
      $display("FAIL exc_drain_flush: stall=%h flush=%h redir=%b pc=%h want 00/1e/1/bfc00380", stall, flush, redirect, redirect_pc);
    end
    tick();
    n_tests++;
    if (redirect !== 1'b0 || exc_busy !== 1'b0 || redirect_pc !== 32'hBFC00380) begin
      n_fail++;
      $display("FAIL exc_drain_after: redir=%b busy=%b pc=%h want 0/0/bfc00380", redirect, exc_busy, redirect_pc);
    end
  endtask

  task automatic test_counter();
    req = 4'b0000; cnt_clr = 1'b1;
    tick();
    n_tests++;
    if (stall_cycles !== 4'h0) begin
      n_fail++; $display("FAIL cnt_clear: cnt=%h want 0", stall_cycles);
    end
    cnt_clr = 1'b0; req = 4'b0001;
    repeat (14) tick();
    n_tests++;
    if (stall_cycles !== 4'hE) begin
      n_fail++; $display("FAIL cnt_14: cnt=%h want e", stall_cycles);
    end
    tick();
    n_tests++;
    if (stall_cycles !== 4'hF) begin
      n_fail++; $display("FAIL cnt_15: cnt=%h want f", stall_cycles);
    end
    repeat (3) tick();
    n_tests++;
    if (stall_cycles !== 4'hF) begin
      n_fail++; $display("FAIL cnt_saturate: cnt=%h want f", stall_cycles);
    end
    cnt_clr = 1'b1;
    tick();
    n_tests++;
    if (stall_cycles !== 4'h0) begin
      n_fail++; $display("FAIL cnt_clr_prio: cnt=%h want 0", stall_cycles);
    end
    cnt_clr = 1'b0; req = 4'b0000;
    repeat (2) tick();
    n_tests++;
    if (stall_cycles !== 4'h0) begin
      n_fail++; $display("FAIL cnt_idle_hold: cnt=%h want 0", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_drain();
    int redir_seen = 0;
    exc_req = 1'b1; exc_target = 32'h12345678; req = 4'b1000;
    tick();
    exc_req = 1'b0;
    #1;
    n_tests++;
    if (stall !== 5'h1F || exc_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_drain: stall=%h busy=%b want 1f/1", stall, exc_busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (stall !== 5'h00 || flush !== 5'h00 || redirect !== 1'b0 || exc_busy !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: stall=%h flush=%h redir=%b busy=%b pc=%h want 00/00/0/0/0",
               stall, flush, redirect, exc_busy, redirect_pc);
    end
    tick();
    rst = 1'b0; req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (redirect !== 1'b0 || exc_busy !== 1'b0) redir_seen++;
      tick();
    end
    n_tests++;
    if (redir_seen != 0 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_after: busy/redirect cycles=%0d pc=%h want 0/0", redir_seen, redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_single_stall();
    test_priority();
    test_exc_idle();
    test_exc_drain();
    test_counter();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core. It turns per-stage stall requests into per-register hold (stall) and bubble (flush) vectors for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences exception entry: freeze the pipeline, drain outstanding bus accesses, flush, then redirect the PC. It also keeps a saturating stall-cycle performance counter.

Parameters:
ADDR_W, 32, width of PC and exception target
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
req  in  4  stall requests: [0] IF (ibus busy), [1] ID (load-use), [2] EX (mul/div busy), [3] MEM (dbus busy)
exc_req  in  1  exception raised by the instruction in MEM
exc_target  in  ADDR_W  handler address, valid with exc_req
cnt_clr  in  1  synchronous clear of stall_cycles
stall  out  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
flush  out  5  bubble enables, same indexing; bit 0 is always 0
redirect  out  1  PC loads redirect_pc this cycle
redirect_pc  out  ADDR_W  registered exception target
exc_busy  out  1  high in any state other than RUN
stall_cycles  out  CNT_W  count of cycles with stall[0]=1

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=RUN, redirect_pc=0, stall_cycles=0.
  - While rst is high: stall=0, flush=0, redirect=0, exc_busy=0.
- States: RUN, FREEZE, DRAIN, FLUSH. The state register is clocked. stall, flush and redirect are combinational decodes of the state and the inputs.
- RUN, exc_req=0 (normal stall):
  - k = highest index with req[k]=1.
  - stall[0..k]=1; flush[k+1]=1 (k=3 gives flush[4]); all other bits 0.
  - No request: stall=0, flush=0.
  - Flush has priority over stall in the pipeline registers. Stall and flush are never both set on the same bit.
- RUN, exc_req=1 (takes priority over req):
  - Latch exc_target into redirect_pc.
  - This cycle: stall=5'b11111, flush=0.
  - Next state: FLUSH if req[0]=0 and req[3]=0, else DRAIN.
  - The same-cycle RUN-to-freeze transition ensures no instruction advances.
- FREEZE: transient alias of the exception-accept cycle above. No separate resident state is required; the encoding may merge it into RUN.
- DRAIN:
  - stall=5'b11111, flush=0.
  - Stay until req[0]=0 and req[3]=0, then go to FLUSH.
  - req[1] and req[2] are ignored.
  - Unbounded wait; the bus guarantees completion.
- FLUSH (exactly one cycle):
  - stall=0, flush=5'b11110, redirect=1 with redirect_pc. The PC loads the target.
  - The faulting instruction is squashed in MEM/WB.
  - Next state: RUN.
- exc_req and exc_target are ignored in DRAIN and FLUSH. redirect_pc changes only on accept.
- exc_busy=1 in the accept cycle, DRAIN and FLUSH.
- A repeated MEM/WB write during the freeze is idempotent and acceptable.
- stall_cycles:
  - Increments when stall[0]=1.
  - Saturates at all-ones; no wrap.
  - cnt_clr has priority over increment: the counter is 0 on the next cycle.
- Reset mid-DRAIN/FLUSH: immediate return to RUN with no redirect; the latched target is cleared.

Decomposition:
- Shared package (defines.v):
  - State encodings: PC_RUN, PC_DRAIN, PC_FLUSH.
  - Stall/flush vector bit indices: PCREG, IFID, IDEX, EXMEM, MEMWB.
  - StallBus width (5).
  - Existing AddrBus/ZeroWord are reused.
- One natural sub-module, pipe_ctrl_prio, a combinational priority decoder req -> {stall, flush}. The counter and FSM stay in the top module.

Test Plan:
- Single-stage stalls: req=4'b0100, no exc -> stall=5'b00111, flush=5'b01000. req=4'b1000 -> stall=5'b01111, flush=5'b10000. req=0 -> both 0.
- Priority: req=4'b0011 -> stall=5'b00011, flush=5'b00100. Highest stage wins and the lower request is subsumed.
- Exception, idle bus: exc_req=1, exc_target=32'hBFC00380, req=0. Accept cycle: stall=5'h1F. Next cycle: flush=5'h1E, redirect=1, redirect_pc=32'hBFC00380. Following cycle: exc_busy=0.
- Exception with drain: exc_req=1 with req[3]=1 held 3 cycles. Stall=5'h1F for 4 cycles, then a single FLUSH cycle. A second exc_req during DRAIN with target 32'h80000180 is ignored; redirect_pc stays 32'hBFC00380.
- Counter: preload near max via 2^CNT_W stall cycles (use CNT_W=4 build). Counter reaches 4'hF and holds. cnt_clr together with stall -> 0 next cycle.
- Async reset asserted mid-DRAIN, between clock edges -> outputs 0 immediately. After release: state RUN, redirect never pulses, redirect_pc=0.
